mesh_drain: RTL

Result drain stage placed directly downstream of the `mesh_db` sorting mesh. After a `start` pulse it waits out the mesh's fixed sort time, then snapshots every PE's `{addr, data}` word in one cycle. It streams the words out in PE-index order over a valid/ready interface, so the host or next stage reads sorted records one per handshake instead of a 256-wide parallel bus. It optionally checks that the address sequence is the identity permutation.

---
 rtl/mesh_drain.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mesh_drain.sv
// rtl/mesh_drain.sv - result drain stage: wait for mesh sort, snapshot all PEs, stream words in PE order
//
// Purpose:
//   After a start pulse, waits SORT_CYCLES cycles for the upstream sorting mesh
//   to settle. It then snapshots every PE word in a single cycle and streams the
//   words out one per valid/ready handshake, in PE-index order.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-low reset
//   start       in   one-cycle pulse: mesh loaded, sorting begins
//   pe_result   in   N*WIDTH flattened mesh outputs, PE[i] at [i*WIDTH +: WIDTH],
//                    address in the upper ADDR_WIDTH bits
//   out_valid   out  beat available
//   out_ready   in   consumer accepts beat
//   out_addr    out  address field of current beat (0 outside streaming)
//   out_data    out  data field of current beat (0 outside streaming)
//   out_last    out  current beat is PE[N-1]
//   busy        out  waiting, capturing or streaming
//   done        out  all N beats transferred (level)
//   err         out  sticky address-order error
//
// Optional feature macro: MESH_DRAIN_CHECK_EN
//   Defined:   each accepted beat's address is compared against its PE index;
//              a mismatch sets err until reset or the next accepted start.
//   Undefined: no comparator; err is tied to 0.

module mesh_drain #(
    parameter int N           = 256,
    parameter int SQRT_N      = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int SORT_CYCLES = 112,
    parameter int WIDTH       = ADDR_WIDTH + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N*WIDTH-1:0]     pe_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int CNT_W = $clog2(SORT_CYCLES + 1);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_CAPTURE = 3'd2,
        S_STREAM  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_snap [N];

    logic               w_hs;
    logic               w_idx_last;
    logic               w_cnt_end;
    logic               w_accept_start;
    logic [WIDTH-1:0]   w_word;

    // Handshake depends only on registered state, so using it in the
    // next-state logic forms no combinational loop with out_valid.
    assign w_hs           = (r_state == S_STREAM) && out_ready;
    assign w_idx_last     = (r_idx == IDX_W'(N - 1));
    assign w_cnt_end      = (r_cnt == CNT_W'(SORT_CYCLES - 1));
    assign w_accept_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_word         = r_snap[r_idx];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_WAIT;
            S_WAIT:    if (w_cnt_end) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_STREAM;
            S_STREAM:  if (w_hs && w_idx_last) w_next = S_DONE;
            S_DONE:    if (start) w_next = S_WAIT;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic: all fields come from registered state/idx and the snapshot
    always_comb begin
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_WAIT, S_CAPTURE: busy = 1'b1;
            S_STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_addr  = w_word[WIDTH-1 -: ADDR_WIDTH];
                out_data  = w_word[DATA_WIDTH-1:0];
                out_last  = w_idx_last;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Sort-wait counter and stream index
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                    end
                end
                S_WAIT:    r_cnt <= r_cnt + 1'b1;
                S_CAPTURE: r_idx <= '0;
                // The last beat moves to DONE instead of wrapping idx.
                S_STREAM:  if (w_hs && !w_idx_last) r_idx <= r_idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Snapshot is deliberately not reset: it is always rewritten before use.
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE) begin
            for (int i = 0; i < N; i++) begin
                r_snap[i] <= pe_result[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MESH_DRAIN_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept_start) begin
            r_err <= 1'b0;
        end else if (w_hs && (out_addr != ADDR_WIDTH'(r_idx))) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_start;
    assign w_unused_start = w_accept_start;
    assign err = 1'b0;
`endif

endmodule
